// File: rtl/line_mem_responder_if.sv
// Line-transfer bus between the L1 data-cache controller (master) and
// the backing line store (slave): request toward memory, ack/data back.
interface line_mem_responder_if #(
    parameter int data_width = 256
);
    logic [31:0]           addr_i;
    logic [data_width-1:0] data_i;
    logic                  cs;
    logic                  we;
    logic                  ack;
    logic [data_width-1:0] data_o;
    logic                  err;

    modport master (
        output addr_i, data_i, cs, we,
        input  ack, data_o, err
    );

    modport slave (
        input  addr_i, data_i, cs, we,
        output ack, data_o, err
    );
endinterface

// File: rtl/line_mem_responder.sv
// Slow-memory responder for the 256-bit line bus. One request at a time,
// serviced after a fixed latency, answered with a single-cycle ack.
// The line store is not reset; everything else is.
module line_mem_responder #(
    parameter int data_width = 256,
    parameter int mem_size   = 2048,
    parameter int delay      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    line_mem_responder_if.slave     bus
);
    // Latency below one cycle is treated as one cycle.
    localparam int EFF_DELAY = (delay < 1) ? 1 : delay;
    localparam int CNT_W     = (EFF_DELAY > 1) ? $clog2(EFF_DELAY) : 1;
    localparam int IDX_W     = $clog2(mem_size);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Backing line store, indexed by line number (preloaded/dumped by benches).
    logic [data_width-1:0] memory [0:mem_size-1];

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [data_width-1:0] r_data;
    logic                  r_we;
    logic                  r_in_range;
    logic                  r_ack;
    logic                  r_err;
    logic [data_width-1:0] r_data_o;

    logic [26:0]           w_line;
    logic                  w_in_range;
    logic                  w_done;
    logic                  w_commit;
    logic [data_width-1:0] w_rd_line;
    logic                  w_unused_bits;

    // Byte offset within the line is irrelevant to a line transfer.
    assign w_unused_bits = ^bus.addr_i[4:0];
    assign w_line        = bus.addr_i[31:5];
    // Range check on the full zero-extended index: no wrap-around.
    assign w_in_range    = ({5'b00000, w_line} < 32'(mem_size));
    assign w_done        = (r_state == ST_BUSY) && (r_cnt == {CNT_W{1'b0}});
    assign w_commit      = w_done && r_we && r_in_range;
    assign w_rd_line     = memory[r_idx];

    assign bus.ack    = r_ack;
    assign bus.err    = r_err;
    assign bus.data_o = r_data_o;

    // Request FSM: latch on accept, count down the latency, pulse ack/err, return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_idx      <= {IDX_W{1'b0}};
            r_data     <= {data_width{1'b0}};
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_data_o   <= {data_width{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cs) begin
                        // Out-of-range requests keep a harmless index; they never touch the store.
                        r_idx      <= w_in_range ? w_line[IDX_W-1:0] : {IDX_W{1'b0}};
                        r_data     <= bus.data_i;
                        r_we       <= bus.we;
                        r_in_range <= w_in_range;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_err   <= ~r_in_range;
                        if (!r_we) begin
                            r_data_o <= r_in_range ? w_rd_line : {data_width{1'b0}};
                        end else begin
                            r_data_o <= r_data_o;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    // cs seen here still belongs to the request just answered.
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Commit an in-range write on its completion edge; reset on that same edge suppresses it.
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            memory[r_idx] <= r_data;
        end
    end
endmodule
